sine_dds_mph: RTL and testbench

//  Multi-phase direct-digital-synthesis sine reference for the VSI modulator.
//  A phase accumulator advances by a tuning word on every sample tick. N_CH phase-shifted

---
 rtl/sine_dds_mph.sv | 198 +++++++++++++++++++
 tb/tb_sine_dds_mph.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sine_dds_mph.sv
// sine_dds_mph: multi-phase DDS sine reference; one quarter-wave table shared by all channels.
// Define AMPL_SCALE_EN to add ampl_in and a registered amplitude-scaling stage (+1 cycle latency).
module sine_dds_mph #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned N_CH    = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en_in,
  input  logic                  tick_in,
  input  logic [PHASE_W-1:0]    ftw_in,
  input  logic                  ovr_clr_in,
  output logic [N_CH*WIDTH-1:0] sine_out,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  ovr_out
`ifdef AMPL_SCALE_EN
  ,
  input  logic [WIDTH-1:0]      ampl_in
`endif
);

  localparam int unsigned Q  = 1 << (ADDR_W - 2);
  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [WIDTH-1:0]   MID     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PHASE_W:0]   PH_FULL = {1'b1, {PHASE_W{1'b0}}};
  localparam logic [PHASE_W:0]   OFFS_X  = PH_FULL / (PHASE_W+1)'(N_CH);
  localparam logic [PHASE_W-1:0] OFFS    = OFFS_X[PHASE_W-1:0];

  // Table entry j = round((MID-1)*sin(2*pi*j/2^ADDR_W)), evaluated at elaboration in Q30 fixed point.
  function automatic logic [WIDTH-2:0] quarter_sine(input int unsigned j);
    longint pi_q, x, x2, term, sum, r;
    pi_q = 64'sd3373259426;
    x    = (pi_q * longint'(j)) / longint'(2 * Q);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int unsigned n = 1; n <= 8; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * longint'((1 << (WIDTH - 1)) - 1) + (longint'(1) <<< 29)) >>> 30;
    return (WIDTH-1)'(r);
  endfunction

  logic [WIDTH-2:0] rom [0:Q];
  for (genvar j = 0; j <= int'(Q); j++) begin : g_rom
    assign rom[j] = quarter_sine(j);
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [PHASE_W-1:0] acc, ph;
  logic [CW-1:0]      ch;
  logic               ch_last, accept, drop, commit;
  logic [ADDR_W-1:0]  k;
  logic [ADDR_W-3:0]  low;
  logic [ADDR_W-2:0]  rom_addr;

  logic               r_vld, r_neg, r_last;
  logic [CW-1:0]      r_ch;
  logic [WIDTH-2:0]   r_mag;

  logic               m_vld, m_neg, m_last;
  logic [CW-1:0]      m_ch;
  logic [WIDTH-2:0]   m_mag;

  logic               f_last;
  logic [WIDTH-1:0]   shadow [N_CH];

  assign k        = ph[PHASE_W-1 -: ADDR_W];
  assign low      = k[ADDR_W-3:0];
  assign rom_addr = k[ADDR_W-2] ? (ADDR_W-1)'(Q) - {1'b0, low} : {1'b0, low};
  assign ch_last  = (ch == CW'(N_CH - 1));

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    commit    = 1'b0;
    valid_out = 1'b0;
    busy_out  = (state != S_IDLE);
    drop      = tick_in && en_in && (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (tick_in && en_in) begin
          accept   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: if (ch_last) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (f_last) begin
          commit   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        valid_out = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= S_IDLE;
      acc     <= '0;
      ph      <= '0;
      ch      <= '0;
      ovr_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc <= acc + ftw_in;
        ph  <= acc + ftw_in;
        ch  <= '0;
      end else if (state == S_FETCH) begin
        ph <= ph + OFFS;
        ch <= ch + CW'(1);
      end else if (state == S_IDLE && !en_in) begin
        acc <= '0;
      end
      if (drop)
        ovr_out <= 1'b1;
      else if (ovr_clr_in)
        ovr_out <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld  <= 1'b0;
      r_neg  <= 1'b0;
      r_last <= 1'b0;
      r_ch   <= '0;
      r_mag  <= '0;
    end else begin
      r_vld  <= (state == S_FETCH);
      r_last <= (state == S_FETCH) && ch_last;
      r_neg  <= k[ADDR_W-1];
      r_ch   <= ch;
      r_mag  <= rom[rom_addr];
    end
  end

`ifdef AMPL_SCALE_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = (2*WIDTH)'(r_mag) * (2*WIDTH)'(ampl_in);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_vld  <= 1'b0;
      m_neg  <= 1'b0;
      m_last <= 1'b0;
      m_ch   <= '0;
      m_mag  <= '0;
    end else begin
      m_vld  <= r_vld;
      m_neg  <= r_neg;
      m_last <= r_last;
      m_ch   <= r_ch;
      m_mag  <= (WIDTH-1)'(prod >> WIDTH);
    end
  end
`else
  assign m_vld  = r_vld;
  assign m_neg  = r_neg;
  assign m_last = r_last;
  assign m_ch   = r_ch;
  assign m_mag  = r_mag;
`endif

  // Fold writes straight into the shadow so the last channel commits one cycle later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      f_last <= 1'b0;
      shadow <= '{default: MID};
    end else begin
      f_last <= m_vld && m_last;
      if (m_vld)
        shadow[m_ch] <= m_neg ? MID - {1'b0, m_mag} : MID + {1'b0, m_mag};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sine_out <= {N_CH{MID}};
    end else if (commit) begin
      for (int unsigned i = 0; i < N_CH; i++)
        sine_out[i*WIDTH +: WIDTH] <= shadow[i];
    end
  end

endmodule

// File: tb/tb_sine_dds_mph.sv
// Scoreboard bench for sine_dds_mph (PHASE_W=16, ADDR_W=8, WIDTH=12, N_CH=3).
module tb_sine_dds_mph;

`ifdef AMPL_SCALE_EN
  localparam int unsigned LAT = 7;
`else
  localparam int unsigned LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, tick, clr;
  logic [15:0] ftw;
  logic [35:0] sine;
  logic        valid, busy, ovr;
`ifdef AMPL_SCALE_EN
  logic [11:0] ampl;
`endif

  sine_dds_mph #(.PHASE_W(16), .ADDR_W(8), .WIDTH(12), .N_CH(3)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .tick_in(tick), .ftw_in(ftw),
    .ovr_clr_in(clr), .sine_out(sine), .valid_out(valid), .busy_out(busy), .ovr_out(ovr)
`ifdef AMPL_SCALE_EN
    , .ampl_in(ampl)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [35:0] vals;
    int unsigned due;
  } exp_t;
  exp_t exp_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every valid pulse must match the oldest pending expectation, on its due cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("valid_has_expect", 48'(exp_q.size()), 48'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", 48'(cyc), 48'(e.due));
        chk("ch0", 48'(sine[11:0]),  48'(e.vals[11:0]));
        chk("ch1", 48'(sine[23:12]), 48'(e.vals[23:12]));
        chk("ch2", 48'(sine[35:24]), 48'(e.vals[35:24]));
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; tick_in is high for exactly the current cycle.
  task automatic do_tick(input logic [15:0] f, input bit expect_it,
                         input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2);
    exp_t e;
    tick = 1'b1;
    ftw  = f;
    if (expect_it) begin
      e.vals = {e2, e1, e0};
      e.due  = cyc + LAT;
      exp_q.push_back(e);
    end
    step(1);
    tick = 1'b0;
    ftw  = 16'($urandom);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sine"},  48'(sine),  48'({3{12'd2048}}));
    chk({tag, "_valid"}, 48'(valid), 48'd0);
    chk({tag, "_busy"},  48'(busy),  48'd0);
    chk({tag, "_ovr"},   48'(ovr),   48'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; ftw = '0; clr = 1'b0;
`ifdef AMPL_SCALE_EN
    ampl = 12'd2048;
`endif
    step(3);
    rst_n = 1'b1;
    step(1);
    chk_reset_state("rst_init");
    en = 1'b1;

`ifdef AMPL_SCALE_EN
    do_tick(16'd16384, 1, 12'd3071, 12'd1544, 12'd1522);
    step(10);
`else
    // ftw=0: k = 0, 85, 170; busy spans accept+1 through the valid cycle
    do_tick(16'd0, 1, 12'd2048, 12'd3829, 12'd292);
    chk("busy_start", 48'(busy), 48'd1);
    step(5);
    chk("busy_valid_cycle", 48'(busy), 48'd1);
    step(1);
    chk("busy_end", 48'(busy), 48'd0);
    chk("valid_end", 48'(valid), 48'd0);
    step(2);

    // Quarter-wave peak then half-period zero crossing
    do_tick(16'd16384, 1, 12'd4095, 12'd1039, 12'd996);
    step(8);
    do_tick(16'd16384, 1, 12'd2048, 12'd267, 12'd3804);
    step(8);
    // 0x8000 + 0xC000 wraps to 0x4000
    do_tick(16'hC000, 1, 12'd4095, 12'd1039, 12'd996);
    step(8);
    do_tick(16'h4000, 1, 12'd2048, 12'd267, 12'd3804);
    step(8);

    // Second tick two cycles later is dropped and flags overrun
    do_tick(16'd0, 1, 12'd2048, 12'd267, 12'd3804);
    step(1);
    chk("ovr_before_drop", 48'(ovr), 48'd0);
    do_tick(16'h1234, 0, 12'd0, 12'd0, 12'd0);
    chk("ovr_set", 48'(ovr), 48'd1);
    step(7);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovr_cleared", 48'(ovr), 48'd0);
    step(2);

    // Drop and clear in the same cycle: set wins
    do_tick(16'd0, 1, 12'd2048, 12'd267, 12'd3804);
    clr = 1'b1;
    do_tick(16'h0F0F, 0, 12'd0, 12'd0, 12'd0);
    clr = 1'b0;
    chk("ovr_set_wins", 48'(ovr), 48'd1);
    step(8);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovr_clr2", 48'(ovr), 48'd0);

    // Tick landing on the valid cycle is dropped
    do_tick(16'd0, 1, 12'd2048, 12'd267, 12'd3804);
    step(5);
    do_tick(16'h7777, 0, 12'd0, 12'd0, 12'd0);
    chk("ovr_valid_cycle_drop", 48'(ovr), 48'd1);
    chk("busy_after_valid", 48'(busy), 48'd0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);

    // en low mid-sequence: run completes, later ticks ignored, acc returns to 0
    do_tick(16'd0, 1, 12'd2048, 12'd267, 12'd3804);
    step(1);
    en = 1'b0;
    do_tick(16'h2222, 0, 12'd0, 12'd0, 12'd0);
    chk("en0_ovr_busy", 48'(ovr), 48'd0);
    step(6);
    for (int i = 0; i < 3; i++) begin
      do_tick(16'h3333, 0, 12'd0, 12'd0, 12'd0);
      step(1);
    end
    chk("en0_ovr", 48'(ovr), 48'd0);
    chk("en0_busy", 48'(busy), 48'd0);
    chk("en0_sine_held", 48'(sine), 48'({12'd3804, 12'd267, 12'd2048}));
    en = 1'b1;
    do_tick(16'd0, 1, 12'd2048, 12'd3829, 12'd292);
    step(8);

    // Reset asserted mid-FETCH with ovr set and a different sample committed
    do_tick(16'd16384, 1, 12'd4095, 12'd1039, 12'd996);
    step(8);
    do_tick(16'd16384, 0, 12'd0, 12'd0, 12'd0);
    do_tick(16'h5555, 0, 12'd0, 12'd0, 12'd0);
    chk("ovr_pre_reset", 48'(ovr), 48'd1);
    rst_n = 1'b0;
    #2;
    chk_reset_state("rst_mid");
    step(2);
    chk_reset_state("rst_hold");
    rst_n = 1'b1;
    step(6);
    chk_reset_state("rst_no_stale");
    do_tick(16'd0, 1, 12'd2048, 12'd3829, 12'd292);
    step(8);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    chk("queue_drained", 48'(exp_q.size()), 48'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
